// File: rtl/accel_mem_responder.sv
// Memory-side responder for the accelerator burst interface: serves read and write bursts from
// one single-port synchronous SRAM, with a 2-entry read return buffer and one status per write.
module accel_mem_responder #(
   parameter int unsigned AWIDTH     = 32,
   parameter int unsigned DWIDTH     = 32,
   parameter int unsigned MEM_AWIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [AWIDTH-1:0]     req_read_addr_i,
   input  logic                  req_read_addr_valid_i,
   output logic                  req_read_addr_ready_o,
   input  logic [31:0]           req_read_len_i,
   output logic [DWIDTH-1:0]     resp_read_data_o,
   output logic                  resp_read_data_valid_o,
   input  logic                  resp_read_data_ready_i,
   input  logic [AWIDTH-1:0]     req_write_addr_i,
   input  logic                  req_write_addr_valid_i,
   output logic                  req_write_addr_ready_o,
   input  logic [31:0]           req_write_len_i,
   input  logic [DWIDTH-1:0]     req_write_data_i,
   input  logic                  req_write_data_valid_i,
   output logic                  req_write_data_ready_o,
   output logic                  resp_write_status_o,
   output logic                  resp_write_status_valid_o,
   input  logic                  resp_write_status_ready_i,
   output logic [MEM_AWIDTH-1:0] mem_addr_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [DWIDTH-1:0]     mem_wdata_o,
   input  logic [DWIDTH-1:0]     mem_rdata_i
);

   typedef enum logic [1:0] {StIdle, StRdBurst, StWrData, StWrResp} state_e;

   state_e            state_q;
   logic              live_q;
   logic              wr_next_q;
   logic [AWIDTH-1:0] addr_q;
   logic [31:0]       len_q;
   logic [31:0]       issued_q;
   logic [31:0]       beats_q;
   logic [DWIDTH-1:0] buf_q [2];
   logic              rptr_q;
   logic              wptr_q;
   logic [1:0]        occ_q;
   logic              infl_q;
   logic              infl_oor_q;
   logic              err_q;

   logic       oor;
   logic       rd_grant;
   logic       wr_grant;
   logic       pop;
   logic       issue;
   logic       wr_beat;
   logic [1:0] occ_after_pop;

   assign oor = |addr_q[AWIDTH-1:MEM_AWIDTH];

   // live_q keeps every ready low while reset is held and for the first cycle after release.
   assign req_read_addr_ready_o  = live_q && (state_q == StIdle) &&
                                   (!req_write_addr_valid_i || !wr_next_q);
   assign req_write_addr_ready_o = live_q && (state_q == StIdle) &&
                                   (!req_read_addr_valid_i || wr_next_q);
   assign rd_grant = req_read_addr_ready_o && req_read_addr_valid_i;
   assign wr_grant = req_write_addr_ready_o && req_write_addr_valid_i;

   assign resp_read_data_valid_o = (occ_q != 2'd0);
   assign resp_read_data_o       = buf_q[rptr_q];
   assign pop                    = resp_read_data_valid_o && resp_read_data_ready_i;

   // A beat leaving this cycle frees its slot, which keeps ready-high bursts at one beat/cycle.
   assign occ_after_pop = occ_q - {1'b0, pop};
   assign issue = (state_q == StRdBurst) && (issued_q != len_q) &&
                  ((occ_after_pop + {1'b0, infl_q}) < 2'd2);

   assign req_write_data_ready_o = (state_q == StWrData);
   assign wr_beat                = req_write_data_ready_o && req_write_data_valid_i;

   assign resp_write_status_valid_o = (state_q == StWrResp);
   assign resp_write_status_o       = (state_q == StWrResp) && !err_q;

   assign mem_en_o    = (issue || wr_beat) && !oor;
   assign mem_we_o    = wr_beat && !oor;
   assign mem_addr_o  = addr_q[MEM_AWIDTH-1:0];
   assign mem_wdata_o = wr_beat ? req_write_data_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         live_q     <= 1'b0;
         wr_next_q  <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         beats_q    <= '0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         rptr_q     <= 1'b0;
         wptr_q     <= 1'b0;
         occ_q      <= '0;
         infl_q     <= 1'b0;
         infl_oor_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         live_q <= 1'b1;
         // SRAM data is valid the cycle after issue; out-of-range beats return zero.
         if (infl_q) begin
            buf_q[wptr_q] <= infl_oor_q ? '0 : mem_rdata_i;
            wptr_q        <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         occ_q      <= occ_q + {1'b0, infl_q} - {1'b0, pop};
         infl_q     <= issue;
         infl_oor_q <= issue && oor;

         case (state_q)
            StIdle: begin
               if (rd_grant) begin
                  wr_next_q <= 1'b1;
                  addr_q    <= req_read_addr_i;
                  len_q     <= req_read_len_i;
                  issued_q  <= '0;
                  beats_q   <= '0;
                  if (req_read_len_i != 32'd0) begin
                     state_q <= StRdBurst;
                  end
               end else if (wr_grant) begin
                  wr_next_q <= 1'b0;
                  addr_q    <= req_write_addr_i;
                  len_q     <= req_write_len_i;
                  beats_q   <= '0;
                  err_q     <= 1'b0;
                  state_q   <= (req_write_len_i == 32'd0) ? StWrResp : StWrData;
               end
            end
            StRdBurst: begin
               if (issue) begin
                  addr_q   <= addr_q + AWIDTH'(1);
                  issued_q <= issued_q + 32'd1;
               end
               if (pop) begin
                  beats_q <= beats_q + 32'd1;
                  if (beats_q == len_q - 32'd1) begin
                     state_q <= StIdle;
                  end
               end
            end
            StWrData: begin
               if (wr_beat) begin
                  addr_q  <= addr_q + AWIDTH'(1);
                  beats_q <= beats_q + 32'd1;
                  if (oor) begin
                     err_q <= 1'b1;
                  end
                  if (beats_q == len_q - 32'd1) begin
                     state_q <= StWrResp;
                  end
               end
            end
            StWrResp: begin
               if (resp_write_status_ready_i) begin
                  err_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_mem_responder.sv
// Bench for accel_mem_responder: directed bursts, a behavioural burst/memory model compared on
// every falling edge, and literal expectations for latency, arbitration and range boundaries.
module tb_accel_mem_responder;
   localparam int unsigned MAW = 12;
   localparam int unsigned MSZ = 1 << MAW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [31:0]    ra, rl, rd_data, wa, wl, wd, mem_wdata, mem_rdata;
   logic           rav, rar, rdv, rdr, wav, war, wdv, wdr, ws, wsv, wsr, mem_en, mem_we;
   logic [MAW-1:0] mem_addr;

   logic [31:0] sram    [MSZ];
   logic [31:0] ref_mem [MSZ];
   logic [31:0] exp_rd   [$];
   logic [31:0] beat_log [$];
   int          total = 0;
   int          bad = 0;

   // Model state, owned by the compare process.
   logic        w_active = 1'b0, w_err = 1'b0, m_resp = 1'b0, m_stat = 1'b0;
   logic [31:0] w_base, w_len, w_idx, a;
   int          rd_issued = 0, rd_popped = 0, rd_len = 0;
   logic        pop_now, exp_we;
   int          n;

   always #5 clk = ~clk;

   accel_mem_responder #(.AWIDTH(32), .DWIDTH(32), .MEM_AWIDTH(MAW)) dut (
      .clk_i                     (clk),
      .rst_ni                    (rst_n),
      .req_read_addr_i           (ra),
      .req_read_addr_valid_i     (rav),
      .req_read_addr_ready_o     (rar),
      .req_read_len_i            (rl),
      .resp_read_data_o          (rd_data),
      .resp_read_data_valid_o    (rdv),
      .resp_read_data_ready_i    (rdr),
      .req_write_addr_i          (wa),
      .req_write_addr_valid_i    (wav),
      .req_write_addr_ready_o    (war),
      .req_write_len_i           (wl),
      .req_write_data_i          (wd),
      .req_write_data_valid_i    (wdv),
      .req_write_data_ready_o    (wdr),
      .resp_write_status_o       (ws),
      .resp_write_status_valid_o (wsv),
      .resp_write_status_ready_i (wsr),
      .mem_addr_o                (mem_addr),
      .mem_en_o                  (mem_en),
      .mem_we_o                  (mem_we),
      .mem_wdata_o               (mem_wdata),
      .mem_rdata_i               (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= sram[mem_addr];
      end
   end

   function automatic void chk(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // Compare process: checks first with the model's current view, then advances the model.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outputs", {rar, war, rdv, rd_data, wdr, ws, wsv, mem_en, mem_we,
                                  mem_addr, mem_wdata}, '0);
            exp_rd.delete();
            w_active = 1'b0;
            m_resp   = 1'b0;
         end else begin
            pop_now = rdv && rdr;
            if (rdv) chk("rd_valid_expected", (exp_rd.size() > 0), 1);
            if (pop_now && exp_rd.size() > 0) begin
               chk("rd_beat", rd_data, exp_rd.pop_front());
               beat_log.push_back(rd_data);
            end
            if (mem_en && !mem_we) begin
               chk("rd_window", ((rd_issued - rd_popped - int'(pop_now)) < 2), 1);
               chk("rd_not_past_len", (rd_issued < rd_len), 1);
               rd_issued++;
            end
            if (pop_now) rd_popped++;

            chk("wdata_ready", wdr, w_active);
            a      = w_base + w_idx;
            exp_we = w_active && wdv && (a < MSZ);
            chk("mem_we", mem_we, exp_we);
            if (w_active) chk("mem_en_wr", mem_en, exp_we);
            if (exp_we) chk("mem_write", {mem_addr, mem_wdata}, {a[MAW-1:0], wd});
            chk("wstatus_valid", wsv, m_resp);
            if (wsv && m_resp) chk("wstatus", ws, m_stat);

            if (wsv && wsr && m_resp) m_resp = 1'b0;
            if (w_active && wdv) begin
               if (a < MSZ) ref_mem[a[MAW-1:0]] = wd;
               else         w_err = 1'b1;
               w_idx = w_idx + 1;
               if (w_idx == w_len) begin
                  w_active = 1'b0;
                  m_resp   = 1'b1;
                  m_stat   = !w_err;
               end
            end
            if (rav && rar) begin
               rd_issued = 0;
               rd_popped = 0;
               rd_len    = int'(rl);
               for (int i = 0; i < int'(rl); i++) begin
                  a = ra + 32'(i);
                  exp_rd.push_back((a >= MSZ) ? 32'd0 : ref_mem[a[MAW-1:0]]);
               end
            end
            if (wav && war) begin
               w_base = wa;
               w_len  = wl;
               w_idx  = 0;
               w_err  = 1'b0;
               if (wl == 0) begin
                  m_resp = 1'b1;
                  m_stat = 1'b1;
               end else begin
                  w_active = 1'b1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rav = 1'b0; wav = 1'b0; wdv = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
   endtask

   task automatic rd_addr(input logic [31:0] addr, input logic [31:0] len);
      int k = 0;
      ra = addr; rl = len; rav = 1'b1;
      #1;
      while (!rar && k < 100) begin tick(); k++; end
      if (!rar) timeout("rd_addr");
      tick();
      rav = 1'b0;
   endtask

   task automatic wr_addr(input logic [31:0] addr, input logic [31:0] len);
      int k = 0;
      wa = addr; wl = len; wav = 1'b1;
      #1;
      while (!war && k < 100) begin tick(); k++; end
      if (!war) timeout("wr_addr");
      tick();
      wav = 1'b0;
   endtask

   task automatic wr_data(input logic [31:0] d);
      int k = 0;
      wd = d; wdv = 1'b1;
      #1;
      while (!wdr && k < 100) begin tick(); k++; end
      if (!wdr) timeout("wr_data");
      tick();
      wdv = 1'b0;
   endtask

   task automatic wait_rd_done();
      int k = 0;
      while ((exp_rd.size() != 0 || rdv) && k < 300) begin tick(); k++; end
      if (k >= 300) timeout("rd_done");
   endtask

   initial begin : main
      for (int i = 0; i < int'(MSZ); i++) begin
         sram[i]    = 32'hA500_0000 + 32'(i);
         ref_mem[i] = 32'hA500_0000 + 32'(i);
      end
      ra = '0; rl = '0; wa = '0; wl = '0; wd = '0;
      rav = 1'b0; wav = 1'b0; wdv = 1'b0; rdr = 1'b1; wsr = 1'b1;
      #2;
      chk("reset_ready", {rar, war, wdr}, 3'b000);
      chk("reset_valid", {rdv, wsv, ws, mem_en, mem_we}, 5'b00000);
      do_reset();

      // Single-beat write, status one cycle after the data beat.
      wr_addr(32'd5, 32'd1);
      wr_data(32'hDEAD);
      chk("t1_status_valid", wsv, 1);
      chk("t1_status", ws, 1);
      tick();
      chk("t1_status_gone", wsv, 0);
      chk("t1_sram", sram[5], 32'hDEAD);

      // Read latency and full throughput.
      wr_addr(32'd4, 32'd3);
      wr_data(32'd1); wr_data(32'd2); wr_data(32'd3);
      beat_log.delete();
      rd_addr(32'd4, 32'd3);
      chk("t2_valid_T", rdv, 0);
      tick(); chk("t2_valid_T1", rdv, 0);
      tick(); chk("t2_beat0", {rdv, rd_data}, {1'b1, 32'd1});
      tick(); chk("t2_beat1", {rdv, rd_data}, {1'b1, 32'd2});
      tick(); chk("t2_beat2", {rdv, rd_data}, {1'b1, 32'd3});
      tick(); chk("t2_done", rdv, 0);

      // Backpressure with ready pattern 1,0,0.
      beat_log.delete();
      rd_addr(32'd100, 32'd9);
      n = 0;
      while (exp_rd.size() != 0 && n < 300) begin
         rdr = ((n % 3) == 0);
         tick();
         n++;
      end
      if (n >= 300) timeout("t3_drain");
      rdr = 1'b1;
      tick();
      chk("t3_count", beat_log.size(), 9);
      chk("t3_first", beat_log[0], 32'hA500_0064);
      chk("t3_last", beat_log[8], 32'hA500_006C);

      // Round-robin arbitration from reset.
      do_reset();
      beat_log.delete();
      ra = 32'd200; rl = 32'd2; wa = 32'd300; wl = 32'd1; rav = 1'b1; wav = 1'b1;
      #1;
      chk("t4_first_rd_ready", rar, 1);
      chk("t4_first_wr_ready", war, 0);
      tick();
      ra = 32'd210; rl = 32'd1;
      n = 0;
      while (!rar && !war && n < 50) begin tick(); n++; end
      chk("t4_second_wr_ready", war, 1);
      chk("t4_second_rd_ready", rar, 0);
      tick();
      wav = 1'b0;
      wr_data(32'h3030);
      rd_addr(32'd210, 32'd1);
      wait_rd_done();
      chk("t4_beats", {beat_log[0], beat_log[1], beat_log[2]},
          {32'hA500_00C8, 32'hA500_00C9, 32'hA500_00D2});
      chk("t4_sram", sram[300], 32'h3030);

      // Range boundary and address wrap.
      wr_addr(32'd4095, 32'd2);
      wr_data(32'h11); wr_data(32'h22);
      chk("t5_status_valid", wsv, 1);
      chk("t5_status", ws, 0);
      tick();
      chk("t5_sram", sram[4095], 32'h11);
      beat_log.delete();
      rd_addr(32'd4096, 32'd1);
      wait_rd_done();
      chk("t5_oor_read", beat_log[0], 32'd0);
      beat_log.delete();
      rd_addr(32'hFFFF_FFFF, 32'd2);
      wait_rd_done();
      chk("t5_wrap", {beat_log[0], beat_log[1]}, {32'd0, 32'hA500_0000});

      // Reset mid-read, then zero-length bursts.
      beat_log.delete();
      rd_addr(32'd20, 32'd4);
      n = 0;
      while (beat_log.size() == 0 && n < 50) begin tick(); n++; end
      if (n >= 50) timeout("t6_first_beat");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_reset_outputs", {rar, war, rdv, wdr, ws, wsv, mem_en, mem_we}, 8'h00);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      rd_addr(32'd30, 32'd0);
      chk("t6_len0_idle", rar, 1);
      for (int i = 0; i < 3; i++) begin
         chk("t6_len0_no_beat", rdv, 0);
         tick();
      end
      wr_addr(32'd40, 32'd0);
      chk("t6_wlen0_status", {wsv, ws}, 2'b11);
      tick();
      chk("t6_wlen0_done", wsv, 0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
